apb4_rr_master_arbiter: RTL and testbench
=========================================

Name: apb4_rr_master_arbiter

Overview:
- APB4 master that shares one APB4 slave port between two local requesters (e.g. two DMA/CPU-side register clients), upstream of an APB4 slave register interface.
- Round-robin arbitration between the two requesters, then the APB SETUP/ACCESS sequence.
- Honours pready wait states and returns prdata/pslverr to the granted requester.

Parameters:
- ADDRWIDTH, 12, width of paddr and of the requester address fields.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  asynchronous reset, active-high.
- reqN_valid  in  1  request pending, N=0,1; held until reqN_ready.
- reqN_addr  in  ADDRWIDTH  request address.
- reqN_write  in  1  1=write, 0=read.
- reqN_wdata  in  32  write data.
- reqN_strb  in  4  write byte strobes.
- reqN_ready  out  1  one-cycle accept pulse; fields captured this cycle.
- rspN_valid  out  1  one-cycle completion pulse.
- rspN_rdata  out  32  read data, valid with rspN_valid.
- rspN_err  out  1  error flag, valid with rspN_valid.
- psel, penable, pwrite  out  1  APB4 master controls.
- paddr  out  ADDRWIDTH  APB address.
- pwdata  out  32  APB write data.
- pstrb  out  4  APB strobes.
- prdata  in  32  APB read data.
- pready  in  1  APB ready; wait states allowed.
- pslverr  in  1  APB error.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer favours req0.
- All APB outputs and rsp outputs are registered.
- States:
  - IDLE: if either reqN_valid is set, pick the winner, pulse its reqN_ready, latch addr/write/wdata/strb into the APB registers, then go to SETUP. Otherwise stay in IDLE.
  - SETUP: psel=1, penable=0. Go to ACCESS unconditionally.
  - ACCESS: psel=1, penable=1, APB signals held stable. If pready=0, stay. If pready=1, register prdata (0 for writes) and pslverr, pulse rspN_valid for the granted N next cycle, drop psel/penable, go to IDLE.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins. The pointer updates on each grant.
- Timing: minimum 4 cycles from reqN_valid rising to rspN_valid (IDLE, SETUP, ACCESS, rsp), plus one per wait state.
- Requester rule: must not re-assert valid between its ready and its rsp. No requirement on the other requester.
- Reads: pwdata=0, pstrb=4'b0000 (APB4 rule). Writes: rspN_rdata=0.
- Simultaneous events:
  - A new valid from the other requester during SETUP/ACCESS waits; it is granted in the following IDLE cycle.
  - A request asserted in the same cycle as rspN_valid is arbitrated normally in that IDLE cycle.
- Reset mid-transfer: immediate return to IDLE; psel/penable drop asynchronously; no rsp issued for the aborted transfer.
- pready/pslverr are ignored outside ACCESS.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - Counter cleared on SETUP entry, incremented each ACCESS cycle with pready=0.
  - At TIMEOUT_CYCLES: abort; psel/penable=0; rspN_valid pulse with rspN_err=1 and rspN_rdata=0; return to IDLE.
  - A late pready after abort is ignored.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Package apb4_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS).
  - request struct typedef (addr, write, wdata, strb).
  - constant APB_DATA_W=32.
- Sub-module apb_rr_arbiter2: two-input round-robin pick with pointer register. Inputs: valid[1:0], advance. Outputs: one-hot grant.

Test Plan:
- req0 write, addr 0x010, wdata 0xA5A5_0001, strb 0xF, pready=1 -> reqN_ready on cycle 0; psel cycles 1-2, penable cycle 2; rsp0_valid cycle 3, rsp0_err=0.
- Both valid from reset -> req0 granted first, then req1. Repeat with both continuously valid -> grants alternate 0,1,0,1.
- req1 read, addr 0x024, pready low 3 cycles, prdata=0xDEAD_BEEF, pslverr=1 -> ACCESS lasts 4 cycles with paddr stable; rsp1_rdata=0xDEADBEEF, rsp1_err=1; pstrb=0 throughout.
- preset asserted during ACCESS -> psel/penable drop the same cycle; no rsp pulse; after release a new req0 is granted first.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready held 0 -> abort after 8 ACCESS cycles; rsp_err=1, rdata=0; a subsequent pready pulse produces no response.

Source files
------------

// File: rtl/apb4_arb_pkg.sv
// Shared types for the two-requester APB4 master: FSM states, request bundle, data width.
// Purely declarative; no latency or backpressure of its own.
package apb4_arb_pkg;

  localparam int APB_DATA_W     = 32;
  localparam int APB_STRB_W     = APB_DATA_W / 8;
  // Request bundles carry a full-width address; the top truncates to ADDRWIDTH.
  localparam int APB_ADDR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_MAX_W-1:0] addr;
    logic                      write;
    logic [APB_DATA_W-1:0]     wdata;
    logic [APB_STRB_W-1:0]     strb;
  } apb_req_t;

endpackage

// File: rtl/apb_rr_arbiter2.sv
// Two-input round-robin pick; grant is combinational, pointer moves on advance.
// Zero latency; when both are valid the one not granted last wins.
module apb_rr_arbiter2 (
  input  logic       pclk,
  input  logic       preset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_gnt = 1 means req1 was granted last, so req0 is favoured next.
  logic last_gnt;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_gnt ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      last_gnt <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_gnt <= grant[1];
    end
  end

endmodule

// File: rtl/apb4_rr_master_arbiter.sv
// APB4 master sharing one slave between two requesters (round-robin); APB_TIMEOUT_EN adds an ACCESS timeout.
// Latency: ready in IDLE, then SETUP, ACCESS (+1 per wait state), rsp pulse next cycle: >= 4 cycles.
// Backpressure: requesters hold valid until their ready pulse; the slave stalls ACCESS with pready.
module apb4_rr_master_arbiter
  import apb4_arb_pkg::*;
#(
  parameter int ADDRWIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  preset,

  input  logic                  req0_valid,
  input  logic [ADDRWIDTH-1:0]  req0_addr,
  input  logic                  req0_write,
  input  logic [APB_DATA_W-1:0] req0_wdata,
  input  logic [APB_STRB_W-1:0] req0_strb,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [APB_DATA_W-1:0] rsp0_rdata,
  output logic                  rsp0_err,

  input  logic                  req1_valid,
  input  logic [ADDRWIDTH-1:0]  req1_addr,
  input  logic                  req1_write,
  input  logic [APB_DATA_W-1:0] req1_wdata,
  input  logic [APB_STRB_W-1:0] req1_strb,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [APB_DATA_W-1:0] rsp1_rdata,
  output logic                  rsp1_err,

  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDRWIDTH-1:0]  paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_STRB_W-1:0] pstrb,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e            state;
  apb_state_e            state_nxt;
  logic [1:0]            req_valid;
  logic [1:0]            grant;
  logic                  do_grant;
  logic                  do_done;
  logic                  do_abort;
  logic                  to_hit;
  logic                  gnt_idx;
  apb_req_t              win_req;
  logic [1:0]            rsp_valid;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  unused_addr_hi;

  assign req_valid = {req1_valid, req0_valid};

  apb_rr_arbiter2 u_arb (
    .pclk    (pclk),
    .preset  (preset),
    .valid   (req_valid),
    .advance (do_grant),
    .grant   (grant)
  );

  always_comb begin
    if (grant[1]) begin
      win_req.addr  = APB_ADDR_MAX_W'(req1_addr);
      win_req.write = req1_write;
      win_req.wdata = req1_wdata;
      win_req.strb  = req1_strb;
    end else begin
      win_req.addr  = APB_ADDR_MAX_W'(req0_addr);
      win_req.write = req0_write;
      win_req.wdata = req0_wdata;
      win_req.strb  = req0_strb;
    end
  end

  assign unused_addr_hi = ^win_req.addr;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // Fires during the last permitted stalled ACCESS cycle.
  assign to_hit = (state == ACCESS) && (to_cnt == TO_LAST);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      to_cnt <= '0;
    end else if (do_grant) begin
      to_cnt <= '0;
    end else if ((state == ACCESS) && !pready && !to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_to_cfg;

  assign to_hit        = 1'b0;
  assign unused_to_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    do_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          do_grant  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end else if (to_hit) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign req0_ready = do_grant & grant[0];
  assign req1_ready = do_grant & grant[1];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      gnt_idx   <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (do_grant) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= win_req.write;
        paddr   <= win_req.addr[ADDRWIDTH-1:0];
        // Reads drive zero data and strobes on the bus.
        pwdata  <= win_req.write ? win_req.wdata : '0;
        pstrb   <= win_req.write ? win_req.strb  : '0;
        gnt_idx <= grant[1];
      end
      if (state == SETUP) begin
        penable <= 1'b1;
      end
      if (do_done || do_abort) begin
        psel               <= 1'b0;
        penable            <= 1'b0;
        rsp_valid[gnt_idx] <= 1'b1;
        rsp_rdata          <= (do_done && !pwrite) ? prdata : '0;
        rsp_err            <= do_abort | pslverr;
      end
    end
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_rdata = rsp_rdata;
  assign rsp1_rdata = rsp_rdata;
  assign rsp0_err   = rsp_err;
  assign rsp1_err   = rsp_err;

endmodule

// File: tb/tb_apb4_rr_master_arbiter.sv
// Bench for apb4_rr_master_arbiter: queued expected responses, APB slave model, directed scenarios.
// Define APB_TIMEOUT_EN to also run the timeout scenario with TIMEOUT_CYCLES=8.
module tb_apb4_rr_master_arbiter;

`ifdef APB_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 256;
`endif

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [11:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic [3:0]  req0_strb = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [11:0] req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic [3:0]  req1_strb = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb4_rr_master_arbiter #(.ADDRWIDTH(12), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .pclk(pclk), .preset(preset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_write(req0_write),
    .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_write(req1_write),
    .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    int          n;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          grants[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  logic        slv_kick = 1'b0;
  int          wcnt = 0;
  exp_t        mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rsp_v(input int n);
    return (n == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic vld(input int n);
    return (n == 0) ? req0_valid : req1_valid;
  endfunction

  function automatic logic cur_write(input int n);
    return (n == 0) ? req0_write : req1_write;
  endfunction

  task automatic set_valid(input int n, input logic v);
    if (n == 0) req0_valid = v;
    else        req1_valid = v;
  endtask

  task automatic set_req(input int n, input logic [11:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
    if (n == 0) begin
      req0_addr = a; req0_write = w; req0_wdata = d; req0_strb = s; req0_valid = 1'b1;
    end else begin
      req1_addr = a; req1_write = w; req1_wdata = d; req1_strb = s; req1_valid = 1'b1;
    end
  endtask

  task automatic push_exp(input int n);
    exp_t e;
    e.n     = n;
    e.rdata = cur_write(n) ? 32'h0 : slv_rdata;
    e.err   = slv_err;
    sb.push_back(e);
  endtask

  // APB slave: wait states, then the configured response; junk data/err outside a ready cycle.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (wcnt >= slv_wait) begin
        pready = 1'b1; prdata = slv_rdata; pslverr = slv_err;
      end else begin
        pready = 1'b0; prdata = 32'hBAD0_BAD0; pslverr = 1'b1; wcnt++;
      end
    end else begin
      wcnt = 0;
      pready = psel | slv_kick; prdata = 32'hBAD0_BAD0; pslverr = 1'b1;
    end
  end

  // Response monitor: every rsp pulse must match the oldest expectation.
  always @(negedge pclk) begin
    if (!preset) begin
      for (int n = 0; n < 2; n++) begin
        if (rsp_v(n)) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_v(n)), 32'h0);
          end else begin
            mon_e = sb.pop_front();
            chk("rsp_owner", n, mon_e.n);
            chk("rsp_rdata", (n == 0) ? rsp0_rdata : rsp1_rdata, mon_e.rdata);
            chk("rsp_err", 32'((n == 0) ? rsp0_err : rsp1_err), 32'(mon_e.err));
          end
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge of the SETUP cycle.
  task automatic issue(input int n, input logic [11:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s);
    int k;
    set_req(n, a, w, d, s);
    #1;
    k = 0;
    while (!rdy(n) && k < 20) begin
      @(negedge pclk); #1; k++;
    end
    chk("issue_ready", 32'(rdy(n)), 32'h1);
    if (rdy(n)) push_exp(n);
    @(negedge pclk);
    set_valid(n, 1'b0);
  endtask

  task automatic count_access(input logic [11:0] a, input logic [3:0] s, output int nacc);
    nacc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge pclk);
      if (psel && penable) begin
        nacc++;
        chk("acc_paddr", 32'(paddr), 32'(a));
        chk("acc_pstrb", 32'(pstrb), 32'(s));
      end else begin
        break;
      end
    end
  endtask

  // Both requesters keep a request up whenever they have one outstanding-free.
  task automatic run_traffic(input int r0, input int r1, input int first);
    int rem[2];
    bit pend[2];
    bit drop[2];
    int cnt;
    int cyc;
    rem[0] = r0; rem[1] = r1;
    pend[0] = 0; pend[1] = 0; drop[0] = 0; drop[1] = 0;
    cnt = 0; cyc = 0;
    grants.delete();
    while ((rem[0] + rem[1]) > 0 || pend[0] || pend[1]) begin
      if (cyc >= 400) break;
      @(negedge pclk);
      cyc++;
      for (int n = 0; n < 2; n++) begin
        if (drop[n]) begin set_valid(n, 1'b0); drop[n] = 0; end
        if (rsp_v(n)) pend[n] = 0;
        if (rem[n] > 0 && !pend[n] && !vld(n)) begin
          set_req(n, 12'h100 + 12'(n * 256 + cnt * 4), cnt[0], $urandom,
                  4'($urandom_range(1, 15)));
          cnt++;
        end
      end
      #1;
      for (int n = 0; n < 2; n++) begin
        if (rdy(n)) begin
          push_exp(n);
          grants.push_back(n);
          pend[n] = 1; rem[n]--; drop[n] = 1;
        end
      end
    end
    chk("traffic_done", 32'(rem[0] + rem[1] + int'(pend[0]) + int'(pend[1])), 32'h0);
    for (int i = 0; i < grants.size(); i++) chk("grant_order", grants[i], (first + i) % 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    repeat (3) @(negedge pclk);
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_pwrite", 32'(pwrite), 32'h0);
    chk("rst_paddr", 32'(paddr), 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", 32'(pstrb), 32'h0);
    chk("rst_rsp0", 32'(rsp0_valid), 32'h0);
    chk("rst_rsp1", 32'(rsp1_valid), 32'h0);
    preset = 1'b0;

    // Both valid from reset: 0,1,0,1,... with mixed reads and writes.
    slv_wait = 0; slv_rdata = 32'h5A5A_C3C3; slv_err = 1'b0;
    run_traffic(3, 3, 0);

    // Single write from req0, zero wait states.
    repeat (2) @(negedge pclk);
    slv_rdata = 32'h1234_5678;
    issue(0, 12'h010, 1'b1, 32'hA5A5_0001, 4'hF);
    chk("w_setup_psel", 32'(psel), 32'h1);
    chk("w_setup_penable", 32'(penable), 32'h0);
    chk("w_setup_pwrite", 32'(pwrite), 32'h1);
    chk("w_setup_paddr", 32'(paddr), 32'h010);
    chk("w_setup_pwdata", pwdata, 32'hA5A5_0001);
    count_access(12'h010, 4'hF, nacc);
    chk("w_access_len", nacc, 1);
    chk("w_rsp0_pulse", 32'(rsp0_valid), 32'h1);
    chk("w_psel_drop", 32'(psel), 32'h0);

    // Read from req1 with 3 wait states and slave error.
    @(negedge pclk);
    slv_wait = 3; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b1;
    issue(1, 12'h024, 1'b0, 32'h1111_2222, 4'hF);
    chk("r_setup_pwdata", pwdata, 32'h0);
    chk("r_setup_pwrite", 32'(pwrite), 32'h0);
    count_access(12'h024, 4'h0, nacc);
    chk("r_access_len", nacc, 4);
    chk("r_rsp1_pulse", 32'(rsp1_valid), 32'h1);

    // Reset during ACCESS: bus drops at once, no response, pointer back to req0.
    @(negedge pclk);
    slv_wait = 1000; slv_err = 1'b0;
    issue(0, 12'h0F0, 1'b0, 32'h0, 4'h0);
    void'(sb.pop_back());
    @(negedge pclk);
    chk("rst_mid_in_access", 32'(penable), 32'h1);
    #2 preset = 1'b1;
    #1;
    chk("rst_mid_psel", 32'(psel), 32'h0);
    chk("rst_mid_penable", 32'(penable), 32'h0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    repeat (5) @(negedge pclk);
    slv_wait = 0; slv_rdata = 32'h0BAD_F00D;
    run_traffic(1, 1, 0);

`ifdef APB_TIMEOUT_EN
    // Slave never ready: abort after 8 ACCESS cycles; a late pready is ignored.
    @(negedge pclk);
    slv_wait = 1000; slv_rdata = 32'h0; slv_err = 1'b1;
    issue(0, 12'h0AC, 1'b0, 32'h0, 4'h0);
    count_access(12'h0AC, 4'h0, nacc);
    chk("to_access_len", nacc, 8);
    chk("to_rsp0_pulse", 32'(rsp0_valid), 32'h1);
    chk("to_rsp0_rdata", rsp0_rdata, 32'h0);
    chk("to_rsp0_err", 32'(rsp0_err), 32'h1);
    slv_kick = 1'b1;
    repeat (2) @(negedge pclk);
    slv_kick = 1'b0;
    repeat (4) @(negedge pclk);
    chk("to_psel_idle", 32'(psel), 32'h0);
`endif

    repeat (5) @(negedge pclk);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
